rf_context_seq: RTL and testbench

- Register-file context sequencer for interrupt entry and exit.
- On a save request it takes ownership of register_file read port A and streams the caller-saved registers to data memory.
- On a restore request it reads them back from memory and writes them through register_file write port W1.
- While idle it passes the core pipeline's port-A read and W1 write straight through to register_file.

---
 rtl/rf_pkg.sv | 22 ++
 rtl/rf_mask_next.sv | 24 ++
 rtl/rf_context_seq.sv | 147 ++++++++++++++
 tb/tb_rf_context_seq.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types, defaults and state encoding for the RF context sequencer
package rf_pkg;
  localparam int DataWidth    = 32;
  localparam int NumRegs      = 32;
  localparam int AddrWidth    = $clog2(NumRegs);
  localparam int MemAddrWidth = 32;

  typedef logic [DataWidth-1:0]    DataT;
  typedef logic [AddrWidth-1:0]    AddrT;
  typedef logic [MemAddrWidth-1:0] MemAddrT;

  // ra, t0-t6, a0-a7
  localparam logic [NumRegs-1:0] CallerSavedMask = 32'hF003_FCE2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_LOAD_REQ,
    S_LOAD_WAIT,
    S_DONE
  } seq_state_e;
endpackage

// File: rtl/rf_mask_next.sv
// rtl/rf_mask_next.sv - priority encoder: lowest set mask bit strictly above cur_i
module rf_mask_next #(
  parameter int                 NumRegs   = 32,
  parameter int                 AddrWidth = 5,
  parameter logic [NumRegs-1:0] Mask      = '0
) (
  input  logic [AddrWidth-1:0] cur_i,
  output logic [AddrWidth-1:0] next_o,
  output logic                 last_o
);
  import rf_pkg::*;

  // Scan downward so the lowest qualifying bit is the one left standing.
  always_comb begin
    next_o = '0;
    last_o = 1'b1;
    for (int i = NumRegs - 1; i >= 0; i--) begin
      if (Mask[i] && (AddrWidth'(i) > cur_i)) begin
        next_o = AddrWidth'(i);
        last_o = 1'b0;
      end
    end
  end
endmodule

// File: rtl/rf_context_seq.sv
// rtl/rf_context_seq.sv - saves/restores caller-saved registers to memory around interrupts
module rf_context_seq #(
  parameter int                 DataWidth    = rf_pkg::DataWidth,
  parameter int                 NumRegs      = rf_pkg::NumRegs,
  parameter int                 AddrWidth    = $clog2(NumRegs),
  parameter int                 MemAddrWidth = rf_pkg::MemAddrWidth,
  parameter logic [NumRegs-1:0] SaveMask     = rf_pkg::CallerSavedMask
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    save_req_i,
  input  logic                    restore_req_i,
  input  logic [MemAddrWidth-1:0] sp_i,
  output logic                    busy_o,
  output logic                    done_o,
  input  logic [AddrWidth-1:0]    core_raddr_a_i,
  output logic [DataWidth-1:0]    core_rdata_a_o,
  input  logic                    core_we_a_i,
  input  logic [AddrWidth-1:0]    core_waddr_a_i,
  input  logic [DataWidth-1:0]    core_wdata_a_i,
  output logic [AddrWidth-1:0]    rf_raddr_a_o,
  input  logic [DataWidth-1:0]    rf_rdata_a_i,
  output logic                    rf_we_a_o,
  output logic [AddrWidth-1:0]    rf_waddr_a_o,
  output logic [DataWidth-1:0]    rf_wdata_a_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [MemAddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DataWidth-1:0]    mem_rdata_i
);
  import rf_pkg::*;

  localparam logic [NumRegs-1:0] Mask = {SaveMask[NumRegs-1:1], 1'b0};

  seq_state_e              state_q, state_d;
  logic [AddrWidth-1:0]    idx_q, idx_d;
  logic [AddrWidth:0]      k_q, k_d;
  logic [MemAddrWidth-1:0] sp_q, sp_d;

  logic [AddrWidth-1:0] first_idx, next_idx;
  logic                 mask_empty, idx_last;

  rf_mask_next #(.NumRegs(NumRegs), .AddrWidth(AddrWidth), .Mask(Mask)) u_first (
    .cur_i  ('0),
    .next_o (first_idx),
    .last_o (mask_empty)
  );

  rf_mask_next #(.NumRegs(NumRegs), .AddrWidth(AddrWidth), .Mask(Mask)) u_next (
    .cur_i  (idx_q),
    .next_o (next_idx),
    .last_o (idx_last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      k_q     <= '0;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      sp_q    <= sp_d;
    end
  end

  // Slot k lives just below the frame top; wrap-around is intentional.
  assign mem_addr_o     = sp_q - ((MemAddrWidth'(k_q) + MemAddrWidth'(1)) << 2);
  assign mem_wdata_o    = rf_rdata_a_i;
  assign core_rdata_a_o = rf_rdata_a_i;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    k_d          = k_q;
    sp_d         = sp_q;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    rf_raddr_a_o = core_raddr_a_i;
    // Gate with reset so no core write slips through while reset is held.
    rf_we_a_o    = core_we_a_i & rst_ni;
    rf_waddr_a_o = core_waddr_a_i;
    rf_wdata_a_o = core_wdata_a_i;

    case (state_q)
      S_IDLE: begin
        if (save_req_i || restore_req_i) begin
          sp_d  = sp_i;
          idx_d = first_idx;
          k_d   = '0;
          if (mask_empty)      state_d = S_DONE;
          else if (save_req_i) state_d = S_SAVE;
          else                 state_d = S_LOAD_REQ;
        end
      end
      S_SAVE: begin
        busy_o       = 1'b1;
        rf_we_a_o    = 1'b0;
        rf_raddr_a_o = idx_q;
        mem_req_o    = 1'b1;
        mem_we_o     = 1'b1;
        if (mem_gnt_i) begin
          if (idx_last) begin
            state_d = S_DONE;
          end else begin
            idx_d = next_idx;
            k_d   = k_q + 1'b1;
          end
        end
      end
      S_LOAD_REQ: begin
        busy_o    = 1'b1;
        rf_we_a_o = 1'b0;
        mem_req_o = 1'b1;
        if (mem_gnt_i) state_d = S_LOAD_WAIT;
      end
      S_LOAD_WAIT: begin
        busy_o    = 1'b1;
        rf_we_a_o = 1'b0;
        if (mem_rvalid_i) begin
          rf_we_a_o    = (idx_q != '0);
          rf_waddr_a_o = idx_q;
          rf_wdata_a_o = mem_rdata_i;
          if (idx_last) begin
            state_d = S_DONE;
          end else begin
            idx_d   = next_idx;
            k_d     = k_q + 1'b1;
            state_d = S_LOAD_REQ;
          end
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_rf_context_seq.sv
// tb/tb_rf_context_seq.sv - directed bench with RF and memory models for rf_context_seq
module tb_rf_context_seq;
  import rf_pkg::*;

  logic    clk = 1'b0;
  logic    rst_ni = 1'b0;
  logic    save_req_i = 1'b0, restore_req_i = 1'b0;
  MemAddrT sp_i = '0;
  logic    busy_o, done_o;
  AddrT    core_raddr_a_i = '0, core_waddr_a_i = '0;
  DataT    core_rdata_a_o, core_wdata_a_i = '0;
  logic    core_we_a_i = 1'b0;
  AddrT    rf_raddr_a_o, rf_waddr_a_o;
  DataT    rf_rdata_a_i, rf_wdata_a_o;
  logic    rf_we_a_o;
  logic    mem_req_o, mem_we_o;
  MemAddrT mem_addr_o;
  DataT    mem_wdata_o;
  logic    mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  DataT    mem_rdata_i = '0;

  rf_context_seq dut (
    .clk_i(clk), .rst_ni(rst_ni), .save_req_i(save_req_i), .restore_req_i(restore_req_i),
    .sp_i(sp_i), .busy_o(busy_o), .done_o(done_o),
    .core_raddr_a_i(core_raddr_a_i), .core_rdata_a_o(core_rdata_a_o),
    .core_we_a_i(core_we_a_i), .core_waddr_a_i(core_waddr_a_i), .core_wdata_a_i(core_wdata_a_i),
    .rf_raddr_a_o(rf_raddr_a_o), .rf_rdata_a_i(rf_rdata_a_i), .rf_we_a_o(rf_we_a_o),
    .rf_waddr_a_o(rf_waddr_a_o), .rf_wdata_a_o(rf_wdata_a_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // Register file model: combinational read, synchronous write, x0 not protected here.
  DataT rf [32] = '{default: '0};
  assign rf_rdata_a_i = rf[rf_raddr_a_o];
  always @(posedge clk) if (rf_we_a_o) rf[rf_waddr_a_o] <= rf_wdata_a_o;

  // Memory model
  DataT    mem [MemAddrT];
  MemAddrT st_addr [$];
  DataT    st_data [$];
  int      ld_cnt = 0;
  logic    load_pending = 1'b0;
  MemAddrT load_addr = '0;
  int      stall_left = 0, max_stall = 0;
  logic    prev_stall = 1'b0;
  MemAddrT p_addr = '0;
  DataT    p_data = '0;
  int      stall_viol = 0, stall_seen = 0;

  always @(posedge clk) begin
    if (mem_req_o && mem_we_o) begin
      if (prev_stall) begin
        stall_seen++;
        if (mem_addr_o !== p_addr || mem_wdata_o !== p_data) stall_viol++;
      end
      prev_stall = !mem_gnt_i;
      p_addr = mem_addr_o;
      p_data = mem_wdata_o;
    end else begin
      prev_stall = 1'b0;
    end
    if (mem_req_o && mem_gnt_i) begin
      if (mem_we_o) begin
        mem[mem_addr_o] = mem_wdata_o;
        st_addr.push_back(mem_addr_o);
        st_data.push_back(mem_wdata_o);
      end else begin
        ld_cnt++;
        load_pending = 1'b1;
        load_addr = mem_addr_o;
      end
    end
  end

  always @(negedge clk) begin
    mem_rvalid_i = 1'b0;
    if (load_pending) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem[load_addr];
      load_pending = 1'b0;
    end
    if (mem_req_o) begin
      if (stall_left == 0) begin
        mem_gnt_i  = 1'b1;
        stall_left = $urandom_range(0, max_stall);
      end else begin
        mem_gnt_i  = 1'b0;
        stall_left--;
      end
    end else begin
      mem_gnt_i = 1'b0;
    end
  end

  int total = 0, bad = 0;
  int saved [16] = '{1, 5, 6, 7, 10, 11, 12, 13, 14, 15, 16, 17, 28, 29, 30, 31};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic DataT pat(input int i);
    if (i == 1) return 32'h1111_1111;
    if (i == 31) return 32'hdead_beef;
    return 32'hA500_0000 | 32'(i);
  endfunction

  task automatic core_write(input int a, input DataT d);
    core_we_a_i = 1'b1; core_waddr_a_i = AddrT'(a); core_wdata_a_i = d;
    tick();
    core_we_a_i = 1'b0;
  endtask

  task automatic run_seq(output int bcyc, output int dcnt, output logic to);
    int after;
    bcyc = 0; dcnt = 0; to = 1'b1; after = 0;
    for (int n = 0; n < 400 && after < 3; n++) begin
      if (busy_o) bcyc++;
      if (done_o) begin dcnt++; to = 1'b0; end
      if (!busy_o) begin core_we_a_i = 1'b0; save_req_i = 1'b0; restore_req_i = 1'b0; end
      if (!to) after++;
      tick();
    end
  endtask

  task automatic start(input logic sv, input logic rs, input MemAddrT sp);
    sp_i = sp; save_req_i = sv; restore_req_i = rs;
    tick();
    save_req_i = 1'b0; restore_req_i = 1'b0;
  endtask

  initial begin
    int   bc, dc;
    logic to;

    // Reset state, with core trying to write
    core_we_a_i = 1'b1; core_waddr_a_i = 5'd4; core_wdata_a_i = 32'h55;
    tick(); tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_we", mem_we_o, 0);
    chk("rst_rf_we", rf_we_a_o, 0);
    core_we_a_i = 1'b0;
    rst_ni = 1'b1;
    tick();

    // IDLE pass-through
    core_write(3, 32'h0000_00AA);
    core_raddr_a_i = 5'd3;
    #1;
    chk("idle_rdata", core_rdata_a_o, 32'h0000_00AA);
    chk("idle_busy", busy_o, 0);
    chk("idle_mem_req", mem_req_o, 0);

    // Save with always-grant memory
    for (int i = 1; i < 32; i++) core_write(i, pat(i));
    start(1'b1, 1'b0, 32'h0000_1000);
    run_seq(bc, dc, to);
    chk("save_timeout", to, 0);
    chk("save_nstores", st_addr.size(), 16);
    chk("save_first_addr", st_addr[0], 32'h0000_0FFC);
    chk("save_first_data", st_data[0], 32'h1111_1111);
    chk("save_last_addr", st_addr[15], 32'h0000_0FC0);
    chk("save_last_data", st_data[15], 32'hdead_beef);
    chk("save_done_cnt", dc, 1);
    chk("save_busy_cycles", bc, 16);
    for (int k = 0; k < 16; k++) chk($sformatf("save_slot%0d", k), st_data[k], pat(saved[k]));

    // Clear RF (x2 kept), then restore
    for (int i = 1; i < 32; i++) if (i != 2) core_write(i, 32'h0);
    start(1'b0, 1'b1, 32'h0000_1000);
    run_seq(bc, dc, to);
    chk("rest_timeout", to, 0);
    chk("rest_loads", ld_cnt, 16);
    chk("rest_busy_cycles", bc, 32);
    chk("rest_done_cnt", dc, 1);
    chk("rest_x1", rf[1], 32'h1111_1111);
    chk("rest_x31", rf[31], 32'hdead_beef);
    chk("rest_x2", rf[2], pat(2));
    chk("rest_x0", rf[0], 32'h0);
    for (int k = 0; k < 16; k++) chk($sformatf("rest_x%0d", saved[k]), rf[saved[k]], pat(saved[k]));

    // Save with grant stalls, core write attempted during busy
    st_addr.delete(); st_data.delete();
    max_stall = 3; stall_left = 2;
    start(1'b1, 1'b0, 32'h0000_2000);
    core_we_a_i = 1'b1; core_waddr_a_i = 5'd5; core_wdata_a_i = 32'h0000_0BAD;
    run_seq(bc, dc, to);
    chk("stall_timeout", to, 0);
    chk("stall_nstores", st_addr.size(), 16);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("stall_addr%0d", k), st_addr[k], 32'h0000_2000 - 32'(4 * (k + 1)));
      chk($sformatf("stall_data%0d", k), st_data[k], pat(saved[k]));
    end
    chk("stall_viol", stall_viol, 0);
    chk("stall_seen", stall_seen > 0, 1);
    chk("busy_core_we_x5", rf[5], pat(5));
    max_stall = 0; stall_left = 0;

    // Both requests: save wins; restore held during busy is ignored
    st_addr.delete(); st_data.delete(); ld_cnt = 0;
    sp_i = 32'h0000_3000; save_req_i = 1'b1; restore_req_i = 1'b1;
    tick();
    save_req_i = 1'b0;
    chk("both_mem_we", mem_we_o, 1);
    chk("both_mem_req", mem_req_o, 1);
    run_seq(bc, dc, to);
    chk("both_timeout", to, 0);
    chk("both_nstores", st_addr.size(), 16);
    chk("both_loads", ld_cnt, 0);
    chk("both_busy_cycles", bc, 16);
    tick();
    chk("both_idle_after", busy_o, 0);

    // Reset in the middle of a save
    st_addr.delete(); st_data.delete();
    start(1'b1, 1'b0, 32'h0000_1000);
    for (int n = 0; n < 50 && st_addr.size() < 5; n++) tick();
    chk("mid_grants", st_addr.size(), 5);
    core_we_a_i = 1'b1;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_mem_req", mem_req_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_rf_we", rf_we_a_o, 0);
    tick(); tick();
    chk("mid_rst_nstores", st_addr.size(), 5);
    core_we_a_i = 1'b0;
    rst_ni = 1'b1;
    tick();
    st_addr.delete(); st_data.delete();
    start(1'b1, 1'b0, 32'h0000_1000);
    run_seq(bc, dc, to);
    chk("restart_timeout", to, 0);
    chk("restart_nstores", st_addr.size(), 16);
    chk("restart_first_addr", st_addr[0], 32'h0000_0FFC);
    st_addr.delete(); st_data.delete();
    start(1'b1, 1'b0, 32'h0000_0008);
    run_seq(bc, dc, to);
    chk("wrap_timeout", to, 0);
    chk("wrap_nstores", st_addr.size(), 16);
    chk("wrap_first_addr", st_addr[0], 32'h0000_0004);
    chk("wrap_last_addr", st_addr[15], 32'hFFFF_FFC8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
